// File: rtl/pkt_stream_arbiter_if.sv
// pkt_stream_arbiter_if
//   Bundles the N_SRC packed ingress AXI-stream sources and the single egress
//   stream of the packet arbiter.
//
//   Ingress (one slice per source, source i in slice i):
//     s_tdata    N_SRC*DATA_W  flit data
//     s_tkeep    N_SRC*KEEP_W  byte enables
//     s_tlast    N_SRC         end of packet
//     s_tvalid   N_SRC         flit valid
//     s_hdr_type N_SRC*8       header type (0 RAW_AXI, 1 ETHERNET, 2 MPI)
//     s_tready   N_SRC         per-source ready (driven by the arbiter)
//   Egress:
//     m_tdata, m_tkeep, m_tlast, m_tvalid, m_tready
//     m_tdest    2             granted source index
//     m_hdr_type 8             header type latched at grant
//
//   Modport master: the arbiter's view. Modport slave: the surrounding
//   sources and the downstream consumer.
interface pkt_stream_arbiter_if #(
    parameter int N_SRC  = 2,
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8
);
    logic [N_SRC*DATA_W-1:0] s_tdata;
    logic [N_SRC*KEEP_W-1:0] s_tkeep;
    logic [N_SRC-1:0]        s_tlast;
    logic [N_SRC-1:0]        s_tvalid;
    logic [N_SRC*8-1:0]      s_hdr_type;
    logic [N_SRC-1:0]        s_tready;

    logic [DATA_W-1:0]       m_tdata;
    logic [KEEP_W-1:0]       m_tkeep;
    logic                    m_tlast;
    logic                    m_tvalid;
    logic                    m_tready;
    logic [1:0]              m_tdest;
    logic [7:0]              m_hdr_type;

    modport master (
        input  s_tdata, s_tkeep, s_tlast, s_tvalid, s_hdr_type, m_tready,
        output s_tready, m_tdata, m_tkeep, m_tlast, m_tvalid, m_tdest, m_hdr_type
    );

    modport slave (
        output s_tdata, s_tkeep, s_tlast, s_tvalid, s_hdr_type, m_tready,
        input  s_tready, m_tdata, m_tkeep, m_tlast, m_tvalid, m_tdest, m_hdr_type
    );
endinterface

// File: rtl/pkt_stream_arbiter.sv
// pkt_stream_arbiter
//   Round-robin, packet-granular arbiter sharing one AXI-stream egress among
//   N_SRC packet sources. A grant is held from the first flit of a packet to
//   its tlast beat; packets longer than MAX_FLITS are cut with a forced tlast
//   and the remainder is arbitrated later as a fresh packet.
//
//   Ports:
//     aclk         clock
//     aresetn      synchronous active-low reset
//     bus          pkt_stream_arbiter_if.master (ingress sources + egress)
//     busy         high while a packet is being transferred
//     pkt_count    packets completed (forced ones included), wraps
//     err_overrun  one-cycle pulse after a packet was truncated
module pkt_stream_arbiter #(
    parameter int N_SRC     = 2,
    parameter int DATA_W    = 64,
    parameter int KEEP_W    = 8,
    parameter int MAX_FLITS = 256,
    parameter int CNT_W     = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    pkt_stream_arbiter_if.master bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     pkt_count,
    output logic                 err_overrun
);

    localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int FW = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
    localparam logic [FW-1:0] FLIT_LAST = FW'(MAX_FLITS - 1);
    localparam logic [GW-1:0] SRC_LAST  = GW'(N_SRC - 1);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t        state;
    logic [GW-1:0] grant;
    logic [GW-1:0] rr_ptr;
    logic [FW-1:0] flit_cnt;
    logic [7:0]    hdr_q;
    logic [GW-1:0] pick_idx;
    logic          pick_valid;
    logic          in_xfer;
    logic          force_last;
    logic          beat;

    assign in_xfer    = (state == XFER);
    assign force_last = (flit_cnt == FLIT_LAST);
    assign beat       = bus.m_tvalid & bus.m_tready;

    // Data path is a straight mux on the held grant, so stalls keep the
    // egress stable for as long as the source holds its flit.
    assign bus.m_tdata    = bus.s_tdata[int'(grant)*DATA_W +: DATA_W];
    assign bus.m_tkeep    = bus.s_tkeep[int'(grant)*KEEP_W +: KEEP_W];
    assign bus.m_tdest    = 2'(grant);
    assign bus.m_hdr_type = hdr_q;

    always_comb begin
        bus.m_tvalid = 1'b0;
        bus.m_tlast  = 1'b0;
        bus.s_tready = '0;
        if (in_xfer) begin
            bus.m_tvalid        = bus.s_tvalid[grant];
            bus.m_tlast         = bus.s_tlast[grant] | force_last;
            bus.s_tready[grant] = bus.m_tready;
        end
    end

    // Scan from rr_ptr upwards (mod N_SRC). Iterating from the far end down
    // lets the nearest requester overwrite any farther one.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (bus.s_tvalid[(int'(rr_ptr) + k) % N_SRC]) begin
                pick_valid = 1'b1;
                pick_idx   = GW'((int'(rr_ptr) + k) % N_SRC);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            flit_cnt    <= '0;
            hdr_q       <= '0;
            busy        <= 1'b0;
            pkt_count   <= '0;
            err_overrun <= 1'b0;
        end else begin
            err_overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant    <= pick_idx;
                        hdr_q    <= bus.s_hdr_type[int'(pick_idx)*8 +: 8];
                        flit_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (beat) begin
                        if (bus.m_tlast) begin
                            pkt_count   <= pkt_count + 1'b1;
                            rr_ptr      <= (grant == SRC_LAST) ? '0 : grant + 1'b1;
                            flit_cnt    <= '0;
                            busy        <= 1'b0;
                            state       <= IDLE;
                            // Truncation only when the source itself did not end here.
                            err_overrun <= force_last & ~bus.s_tlast[grant];
                        end else begin
                            flit_cnt <= flit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_stream_arbiter.sv
// tb_pkt_stream_arbiter
//   Directed bench for pkt_stream_arbiter (N_SRC=2, MAX_FLITS=4). Each source
//   is fed from a flit queue; entries with valid=0 model a gap of one cycle.
//   Egress beats are logged and compared against hand-computed sequences.
module tb_pkt_stream_arbiter;

    localparam int N_SRC     = 2;
    localparam int DATA_W    = 64;
    localparam int KEEP_W    = 8;
    localparam int MAX_FLITS = 4;
    localparam int CNT_W     = 32;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic             busy;
    logic [CNT_W-1:0] pkt_count;
    logic             err_overrun;

    pkt_stream_arbiter_if #(.N_SRC(N_SRC), .DATA_W(DATA_W), .KEEP_W(KEEP_W)) bus();

    pkt_stream_arbiter #(
        .N_SRC(N_SRC), .DATA_W(DATA_W), .KEEP_W(KEEP_W),
        .MAX_FLITS(MAX_FLITS), .CNT_W(CNT_W)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus.master),
        .busy(busy),
        .pkt_count(pkt_count),
        .err_overrun(err_overrun)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        valid;
        logic [63:0] data;
        logic        last;
    } flit_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [1:0]  dest;
        logic [7:0]  hdr;
        int          cyc;
    } beat_t;

    flit_t       src_q0[$];
    flit_t       src_q1[$];
    logic [7:0]  src_hdr[2];
    logic [7:0]  src_keep[2];
    logic        rdy_pat[$];
    beat_t       beats[$];
    logic        busy_hist[$];
    int          cyc, err_pulses, err_cyc, stall_cycles, stall_bad, s0_rdy_seen;
    logic        prev_stall, prev_last;
    logic [63:0] prev_data;
    logic [1:0]  prev_dest;
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic flit_t mk(input logic v, input logic [63:0] d, input logic l);
        flit_t f;
        f.valid = v;
        f.data  = d;
        f.last  = l;
        return f;
    endfunction

    task automatic clear_logs();
        beats.delete();
        busy_hist.delete();
        cyc = 0; err_pulses = 0; err_cyc = -1;
        stall_cycles = 0; stall_bad = 0; s0_rdy_seen = 0; prev_stall = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        src_q0.delete(); src_q1.delete(); rdy_pat.delete();
        bus.s_tvalid = '0; bus.s_tlast = '0; bus.s_tdata = '0;
        bus.s_tkeep = '1; bus.s_hdr_type = '0; bus.m_tready = 1'b1;
        src_hdr[0] = 8'h00; src_hdr[1] = 8'h00;
        src_keep[0] = 8'hFF; src_keep[1] = 8'hFF;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        clear_logs();
    endtask

    // One clock cycle: present queue heads, sample at negedge, pop accepted flits.
    task automatic step();
        logic [1:0] rdy;
        beat_t      b;
        bus.s_tvalid = '0;
        bus.s_tlast  = '0;
        if (src_q0.size() > 0) begin
            bus.s_tvalid[0] = src_q0[0].valid; bus.s_tdata[63:0] = src_q0[0].data; bus.s_tlast[0] = src_q0[0].last;
        end
        if (src_q1.size() > 0) begin
            bus.s_tvalid[1] = src_q1[0].valid; bus.s_tdata[127:64] = src_q1[0].data; bus.s_tlast[1] = src_q1[0].last;
        end
        bus.s_hdr_type = {src_hdr[1], src_hdr[0]};
        bus.s_tkeep    = {src_keep[1], src_keep[0]};
        bus.m_tready   = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
        @(negedge aclk);
        busy_hist.push_back(busy);
        rdy = bus.s_tready;
        if (rdy[0]) s0_rdy_seen++;
        if (err_overrun) begin err_pulses++; err_cyc = cyc; end
        if (prev_stall && (bus.m_tdata !== prev_data || bus.m_tlast !== prev_last ||
                           bus.m_tdest !== prev_dest || bus.m_tvalid !== 1'b1)) stall_bad++;
        prev_stall = bus.m_tvalid && !bus.m_tready;
        prev_data  = bus.m_tdata; prev_last = bus.m_tlast; prev_dest = bus.m_tdest;
        if (prev_stall) stall_cycles++;
        if (bus.m_tvalid && bus.m_tready) begin
            b.data = bus.m_tdata; b.keep = bus.m_tkeep; b.last = bus.m_tlast;
            b.dest = bus.m_tdest; b.hdr = bus.m_hdr_type; b.cyc = cyc;
            beats.push_back(b);
        end
        @(posedge aclk);
        if (src_q0.size() > 0 && (!src_q0[0].valid || rdy[0])) src_q0.delete(0);
        if (src_q1.size() > 0 && (!src_q1[0].valid || rdy[1])) src_q1.delete(0);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        bus.s_tvalid = 2'b11; bus.s_tlast = '0; bus.s_tdata = '0; bus.s_tkeep = '1;
        bus.s_hdr_type = 16'h0201; bus.m_tready = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        n_checks++; if (bus.m_tvalid !== 1'b0) $display("[TB] FAIL reset_m_tvalid got=%0b want=0", bus.m_tvalid); else n_pass++;
        n_checks++; if (bus.s_tready !== 2'b00) $display("[TB] FAIL reset_s_tready got=%0b want=00", bus.s_tready); else n_pass++;
        n_checks++; if (bus.m_tdest !== 2'd0) $display("[TB] FAIL reset_m_tdest got=%0d want=0", bus.m_tdest); else n_pass++;
        n_checks++; if (bus.m_hdr_type !== 8'd0) $display("[TB] FAIL reset_hdr got=%0h want=0", bus.m_hdr_type); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%0b want=0", busy); else n_pass++;
        n_checks++; if (pkt_count !== 32'd0) $display("[TB] FAIL reset_pkt_count got=%0d want=0", pkt_count); else n_pass++;
        n_checks++; if (err_overrun !== 1'b0) $display("[TB] FAIL reset_err got=%0b want=0", err_overrun); else n_pass++;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        bus.s_tvalid = '0;
    endtask

    task automatic test_single();
        logic [63:0] exp_d[3] = '{64'h11, 64'h22, 64'h33};
        logic        exp_l[3] = '{1'b0, 1'b0, 1'b1};
        do_reset();
        src_hdr[0] = 8'd1;
        src_q0.push_back(mk(1, 64'h11, 0));
        src_q0.push_back(mk(1, 64'h22, 0));
        src_q0.push_back(mk(1, 64'h33, 1));
        run(6);
        n_checks++; if (busy_hist[0] !== 1'b0) $display("[TB] FAIL single_busy_c0 got=%0b want=0", busy_hist[0]); else n_pass++;
        n_checks++; if (busy_hist[1] !== 1'b1) $display("[TB] FAIL single_busy_c1 got=%0b want=1", busy_hist[1]); else n_pass++;
        n_checks++; if (busy_hist[4] !== 1'b0) $display("[TB] FAIL single_busy_c4 got=%0b want=0", busy_hist[4]); else n_pass++;
        n_checks++; if (beats.size() != 3) $display("[TB] FAIL single_nbeats got=%0d want=3", beats.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= beats.size()) $display("[TB] FAIL single_beat%0d got=none want=%0h", i, exp_d[i]);
            else if (beats[i].data !== exp_d[i] || beats[i].last !== exp_l[i])
                $display("[TB] FAIL single_beat%0d got=%0h/%0b want=%0h/%0b", i, beats[i].data, beats[i].last, exp_d[i], exp_l[i]);
            else n_pass++;
        end
        if (beats.size() > 0) begin
            n_checks++; if (beats[0].cyc != 1) $display("[TB] FAIL single_first_cyc got=%0d want=1", beats[0].cyc); else n_pass++;
            n_checks++; if (beats[0].dest !== 2'd0) $display("[TB] FAIL single_dest got=%0d want=0", beats[0].dest); else n_pass++;
            n_checks++; if (beats[0].hdr !== 8'd1) $display("[TB] FAIL single_hdr got=%0h want=1", beats[0].hdr); else n_pass++;
        end
        n_checks++; if (pkt_count !== 32'd1) $display("[TB] FAIL single_pkt_count got=%0d want=1", pkt_count); else n_pass++;
    endtask

    task automatic test_contention();
        logic [63:0] exp_d[12] = '{64'hA0, 64'hA1, 64'hB0, 64'hB1, 64'hA2, 64'hA3,
                                   64'hB2, 64'hB3, 64'hA4, 64'hA5, 64'hB4, 64'hB5};
        logic [1:0]  exp_t[12] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
        do_reset();
        src_hdr[0] = 8'd1; src_hdr[1] = 8'd1;
        for (int p = 0; p < 3; p++) begin
            src_q0.push_back(mk(1, 64'hA0 + 64'(2*p), 0)); src_q0.push_back(mk(1, 64'hA1 + 64'(2*p), 1));
            src_q1.push_back(mk(1, 64'hB0 + 64'(2*p), 0)); src_q1.push_back(mk(1, 64'hB1 + 64'(2*p), 1));
        end
        run(20);
        n_checks++; if (beats.size() != 12) $display("[TB] FAIL cont_nbeats got=%0d want=12", beats.size()); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (i >= beats.size()) $display("[TB] FAIL cont_beat%0d got=none want=%0h", i, exp_d[i]);
            else if (beats[i].data !== exp_d[i] || beats[i].dest !== exp_t[i])
                $display("[TB] FAIL cont_beat%0d got=%0h/d%0d want=%0h/d%0d", i, beats[i].data, beats[i].dest, exp_d[i], exp_t[i]);
            else n_pass++;
        end
        if (beats.size() > 2) begin
            n_checks++; if (beats[2].cyc - beats[1].cyc != 2) $display("[TB] FAIL cont_bubble got=%0d want=2", beats[2].cyc - beats[1].cyc); else n_pass++;
        end
        n_checks++; if (pkt_count !== 32'd6) $display("[TB] FAIL cont_pkt_count got=%0d want=6", pkt_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_d[4] = '{64'hC0, 64'hC1, 64'hC2, 64'hC3};
        do_reset();
        src_hdr[1] = 8'd2; src_keep[1] = 8'h0F;
        for (int i = 0; i < 4; i++) src_q1.push_back(mk(1, 64'hC0 + 64'(i), (i == 3)));
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        run(9);
        n_checks++; if (beats.size() != 4) $display("[TB] FAIL bp_nbeats got=%0d want=4", beats.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= beats.size()) $display("[TB] FAIL bp_beat%0d got=none want=%0h", i, exp_d[i]);
            else if (beats[i].data !== exp_d[i] || beats[i].last !== (i == 3))
                $display("[TB] FAIL bp_beat%0d got=%0h/%0b want=%0h/%0b", i, beats[i].data, beats[i].last, exp_d[i], (i == 3));
            else n_pass++;
        end
        if (beats.size() > 0) begin
            n_checks++; if (beats[0].hdr !== 8'd2) $display("[TB] FAIL bp_hdr got=%0h want=2", beats[0].hdr); else n_pass++;
            n_checks++; if (beats[0].dest !== 2'd1) $display("[TB] FAIL bp_dest got=%0d want=1", beats[0].dest); else n_pass++;
            n_checks++; if (beats[0].keep !== 8'h0F) $display("[TB] FAIL bp_keep got=%0h want=0f", beats[0].keep); else n_pass++;
        end
        n_checks++; if (stall_cycles != 2) $display("[TB] FAIL bp_stall_cycles got=%0d want=2", stall_cycles); else n_pass++;
        n_checks++; if (stall_bad != 0) $display("[TB] FAIL bp_stall_stable got=%0d want=0", stall_bad); else n_pass++;
        n_checks++; if (s0_rdy_seen != 0) $display("[TB] FAIL bp_s0_ready got=%0d want=0", s0_rdy_seen); else n_pass++;
    endtask

    task automatic test_overrun();
        logic exp_l[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 6; i++) src_q0.push_back(mk(1, 64'hD0 + 64'(i), (i == 5)));
        run(10);
        n_checks++; if (beats.size() != 6) $display("[TB] FAIL ovr_nbeats got=%0d want=6", beats.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= beats.size()) $display("[TB] FAIL ovr_beat%0d got=none want=%0h", i, 64'hD0 + 64'(i));
            else if (beats[i].data !== 64'hD0 + 64'(i) || beats[i].last !== exp_l[i])
                $display("[TB] FAIL ovr_beat%0d got=%0h/%0b want=%0h/%0b", i, beats[i].data, beats[i].last, 64'hD0 + 64'(i), exp_l[i]);
            else n_pass++;
        end
        n_checks++; if (err_pulses != 1) $display("[TB] FAIL ovr_err_pulses got=%0d want=1", err_pulses); else n_pass++;
        n_checks++; if (err_cyc != 5) $display("[TB] FAIL ovr_err_cycle got=%0d want=5", err_cyc); else n_pass++;
        n_checks++; if (pkt_count !== 32'd2) $display("[TB] FAIL ovr_pkt_count got=%0d want=2", pkt_count); else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        src_hdr[1] = 8'h07;
        src_q0.push_back(mk(1, 64'h5A, 1));
        src_q1.push_back(mk(0, 64'h0, 0));
        for (int i = 0; i < 5; i++) src_q1.push_back(mk(1, 64'hE0 + 64'(i), (i == 4)));
        rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        run(5);
        n_checks++; if (beats.size() != 3) $display("[TB] FAIL mrst_pre_nbeats got=%0d want=3", beats.size()); else n_pass++;
        if (beats.size() > 2) begin
            n_checks++; if (beats[2].data !== 64'hE1 || beats[2].last !== 1'b0)
                $display("[TB] FAIL mrst_flit2 got=%0h/%0b want=e1/0", beats[2].data, beats[2].last); else n_pass++;
            n_checks++; if (beats[2].hdr !== 8'h07) $display("[TB] FAIL mrst_hdr_pass got=%0h want=07", beats[2].hdr); else n_pass++;
        end
        n_checks++; if (pkt_count !== 32'd1) $display("[TB] FAIL mrst_pre_count got=%0d want=1", pkt_count); else n_pass++;
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        n_checks++; if (bus.m_tvalid !== 1'b0) $display("[TB] FAIL mrst_m_tvalid got=%0b want=0", bus.m_tvalid); else n_pass++;
        n_checks++; if (bus.s_tready !== 2'b00) $display("[TB] FAIL mrst_s_tready got=%0b want=00", bus.s_tready); else n_pass++;
        n_checks++; if (bus.m_tdest !== 2'd0) $display("[TB] FAIL mrst_m_tdest got=%0d want=0", bus.m_tdest); else n_pass++;
        n_checks++; if (bus.m_hdr_type !== 8'd0) $display("[TB] FAIL mrst_hdr got=%0h want=0", bus.m_hdr_type); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL mrst_busy got=%0b want=0", busy); else n_pass++;
        n_checks++; if (pkt_count !== 32'd0) $display("[TB] FAIL mrst_pkt_count got=%0d want=0", pkt_count); else n_pass++;
        n_checks++; if (err_overrun !== 1'b0) $display("[TB] FAIL mrst_err got=%0b want=0", err_overrun); else n_pass++;
        src_q0.delete(); src_q1.delete(); rdy_pat.delete();
        clear_logs();
        src_q0.push_back(mk(1, 64'h60, 1));
        src_q1.push_back(mk(1, 64'h61, 1));
        run(6);
        n_checks++; if (beats.size() != 2) $display("[TB] FAIL mrst_post_nbeats got=%0d want=2", beats.size()); else n_pass++;
        if (beats.size() > 1) begin
            n_checks++; if (beats[0].dest !== 2'd0 || beats[0].data !== 64'h60)
                $display("[TB] FAIL mrst_rr_restart got=%0h/d%0d want=60/d0", beats[0].data, beats[0].dest); else n_pass++;
            n_checks++; if (beats[1].dest !== 2'd1) $display("[TB] FAIL mrst_second_dest got=%0d want=1", beats[1].dest); else n_pass++;
        end
    endtask

    task automatic test_valid_gap();
        logic [63:0] exp_d[4] = '{64'hF1, 64'hF2, 64'hA1, 64'hA2};
        logic [1:0]  exp_t[4] = '{1, 1, 0, 0};
        do_reset();
        src_hdr[0] = 8'd1; src_hdr[1] = 8'd1;
        src_q0.push_back(mk(0, 64'h0, 0));
        src_q0.push_back(mk(1, 64'hA1, 0));
        src_q0.push_back(mk(1, 64'hA2, 1));
        src_q1.push_back(mk(1, 64'hF1, 0));
        repeat (3) src_q1.push_back(mk(0, 64'h0, 0));
        src_q1.push_back(mk(1, 64'hF2, 1));
        run(11);
        n_checks++; if (beats.size() != 4) $display("[TB] FAIL gap_nbeats got=%0d want=4", beats.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= beats.size()) $display("[TB] FAIL gap_beat%0d got=none want=%0h", i, exp_d[i]);
            else if (beats[i].data !== exp_d[i] || beats[i].dest !== exp_t[i])
                $display("[TB] FAIL gap_beat%0d got=%0h/d%0d want=%0h/d%0d", i, beats[i].data, beats[i].dest, exp_d[i], exp_t[i]);
            else n_pass++;
        end
        if (beats.size() > 2) begin
            n_checks++; if (beats[1].cyc - beats[0].cyc != 4) $display("[TB] FAIL gap_hold got=%0d want=4", beats[1].cyc - beats[0].cyc); else n_pass++;
            n_checks++; if (beats[2].cyc != 7) $display("[TB] FAIL gap_src0_cyc got=%0d want=7", beats[2].cyc); else n_pass++;
        end
        n_checks++; if (busy_hist[3] !== 1'b1) $display("[TB] FAIL gap_busy got=%0b want=1", busy_hist[3]); else n_pass++;
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_overrun();
        test_mid_reset();
        test_valid_gap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pkt_stream_arbiter.md
Name: pkt_stream_arbiter

Overview:
- Round-robin, packet-granular arbiter that shares one 64-bit AXI-stream egress between N_SRC packet sources, each an Ethernet, MPI or raw-AXI packet stream.
- Sits between the per-source packet generators/parsers and the single downstream packet consumer.
- Locks the grant from the first flit to the `tlast` flit, tags the egress with the source index and header type, and bounds packet length.

Parameters:
- N_SRC, 2, number of source streams (2..4).
- DATA_W, 64, flit data width in bits.
- KEEP_W, 8, byte-enable width (DATA_W/8).
- MAX_FLITS, 256, maximum flits per packet before a forced `tlast`.
- CNT_W, 32, width of the packet counter.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous, active-low reset.
- s_tdata  in  N_SRC*DATA_W  packed per-source flit data; source i occupies slice i.
- s_tkeep  in  N_SRC*KEEP_W  per-source byte enables.
- s_tlast  in  N_SRC  per-source end-of-packet.
- s_tvalid  in  N_SRC  per-source flit valid.
- s_hdr_type  in  N_SRC*8  per-source header type: 0 = RAW_AXI, 1 = ETHERNET, 2 = MPI. Sampled at grant.
- s_tready  out  N_SRC  per-source ready.
- m_tdata  out  DATA_W  egress flit data.
- m_tkeep  out  KEEP_W  egress byte enables.
- m_tlast  out  1  egress end-of-packet.
- m_tvalid  out  1  egress valid.
- m_tready  in  1  egress ready.
- m_tdest  out  2  index of the granted source.
- m_hdr_type  out  8  header type latched at grant.
- busy  out  1  high while in XFER.
- pkt_count  out  CNT_W  packets completed, including forced ones.
- err_overrun  out  1  one-cycle pulse when a packet is truncated.

Behaviour:
- Reset (aresetn low at a rising edge) takes priority over everything and may occur mid-packet.
  - Outputs: m_tvalid=0, s_tready=0, m_tdest=0, m_hdr_type=0, busy=0, pkt_count=0, err_overrun=0.
  - Internal: state=IDLE, rr_ptr=0, flit_cnt=0.
  - A partially sent packet is abandoned; no forced `tlast` is emitted.
- State IDLE:
  - busy=0, m_tvalid=0, all s_tready=0.
  - If any s_tvalid is high, pick the first index i scanning rr_ptr, rr_ptr+1, … modulo N_SRC with s_tvalid[i]=1.
  - Register grant=i and m_hdr_type=s_hdr_type[i]; clear flit_cnt; move to XFER.
  - Grant latency: exactly one cycle from s_tvalid to busy=1. One bubble cycle occurs between consecutive packets.
- State XFER (grant g):
  - Combinational pass-through:
    - m_tdata, m_tkeep, m_tvalid taken from source g.
    - m_tlast = s_tlast[g] OR force.
    - s_tready[g] = m_tready; all other s_tready=0.
  - m_tdest=g; busy=1.
  - Beat: m_tvalid & m_tready. Each beat increments flit_cnt.
  - force is high when flit_cnt == MAX_FLITS-1.
  - Grant is held even if s_tvalid[g] drops mid-packet; no re-arbitration until a last beat.
  - On a beat with m_tlast=1:
    - pkt_count increments, wrapping modulo 2^CNT_W.
    - rr_ptr = (g+1) mod N_SRC.
    - state returns to IDLE.
  - If that beat was forced (force=1 and s_tlast[g]=0), err_overrun pulses high for the following cycle. The source's remaining flits are arbitrated later as a new packet.
- Simultaneous requests are resolved by rr_ptr only; each source gets at most one packet per round while others are waiting.
- Stalls (m_tready low) hold all egress signals stable and do not advance flit_cnt. AXI-stream rules hold: valid is never dropped without a beat unless the source drops it.
- Width rules:
  - flit_cnt is wide enough for MAX_FLITS-1.
  - m_tdest is zero-extended from clog2(N_SRC).
  - Unused s_hdr_type values are passed through unchanged.

Test Plan:
- Single source: src0 sends 3 flits (0x11, 0x22, 0x33 with tlast), hdr_type=1, m_tready=1 -> busy rises one cycle after valid; m_tdata sequence 0x11, 0x22, 0x33 with m_tlast on the 3rd flit; m_tdest=0; m_hdr_type=1; pkt_count=1.
- Contention: src0 and src1 each hold 2-flit packets continuously, 3 packets each -> egress order src0, src1, src0, src1, src0, src1; one idle cycle between packets; pkt_count=6.
- Backpressure: m_tready toggles 1,0,0,1 during a 4-flit MPI packet (hdr_type=2) from src1 -> data stays stable while stalled; s_tready[0]=0 throughout; all 4 flits delivered in order.
- Overrun: MAX_FLITS=4, src0 sends 6 flits with tlast only on the 6th -> m_tlast forced on the 4th flit; err_overrun pulses once; flits 5-6 delivered as a second packet; pkt_count=2.
- Mid-packet reset: aresetn low for 1 cycle after flit 2 of a 5-flit packet -> all outputs at reset values; next arbitration starts from rr_ptr=0.
- Valid gap: src1 granted, drops s_tvalid for 3 cycles mid-packet while src0 is valid -> grant remains 1; src0 is served only after src1's tlast.
